// File: rtl/div_unit_slot_if.sv
// Handshake and data bundle between a MulDiv issue lane and its divider slot.
// The master side (issue/execute) drives the flush/stall qualifiers, the
// acquire/request/release handshake and the operands. The slave side (the
// divider) returns the one-hot slot status, the result and the reservation
// owner.
interface div_unit_slot_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int AL_INDEX_WIDTH = 6
);
    logic                      flush;
    logic                      stall;
    logic                      divAcquire;
    logic [AL_INDEX_WIDTH-1:0] acquireActiveListPtr;
    logic                      divReq;
    logic [DATA_WIDTH-1:0]     dataInA;
    logic [DATA_WIDTH-1:0]     dataInB;
    logic [1:0]                divCode;
    logic                      divRelease;
    logic                      divFree;
    logic                      divReserved;
    logic                      divBusy;
    logic                      divFinished;
    logic [DATA_WIDTH-1:0]     divDataOut;
    logic [AL_INDEX_WIDTH-1:0] reservedActiveListPtr;

    modport master (
        output flush, stall, divAcquire, acquireActiveListPtr, divReq,
               dataInA, dataInB, divCode, divRelease,
        input  divFree, divReserved, divBusy, divFinished, divDataOut,
               reservedActiveListPtr
    );

    modport slave (
        input  flush, stall, divAcquire, acquireActiveListPtr, divReq,
               dataInA, dataInB, divCode, divRelease,
        output divFree, divReserved, divBusy, divFinished, divDataOut,
               reservedActiveListPtr
    );
endinterface

// File: rtl/div_unit_slot.sv
// Iterative restoring radix-2 divider slot for one MulDiv issue lane.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - div_unit_slot_if.slave: flush/stall, acquire/req/release handshake,
//          operands and divCode (0=DIV 1=DIVU 2=REM 3=REMU) in; one-hot
//          status, result and reservation owner out.
//
// state        | meaning
// S_FREE       | slot idle, may be acquired
// S_RESERVED   | owned by an issued op, waiting for divReq
// S_PROCESSING | iterating (or one cycle for divide-by-zero / overflow)
// S_FINISHED   | result valid on divDataOut until released
module div_unit_slot #(
    parameter int DATA_WIDTH     = 32,
    parameter int AL_INDEX_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst,
    div_unit_slot_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_FREE, S_RESERVED, S_PROCESSING, S_FINISHED} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [AL_INDEX_WIDTH-1:0] r_ptr;
    logic [1:0]                r_code;
    logic                      r_qneg;
    logic                      r_rneg;
    logic                      r_special;
    logic [CW-1:0]             r_iter;
    logic [DATA_WIDTH:0]       r_rem;
    logic [DATA_WIDTH-1:0]     r_quo;
    logic [DATA_WIDTH-1:0]     r_div;
    logic [DATA_WIDTH-1:0]     r_result;

    logic                      w_accept_acq;
    logic                      w_start;
    logic                      w_last;
    logic                      w_signed;
    logic                      w_neg_a;
    logic                      w_neg_b;
    logic [DATA_WIDTH-1:0]     w_mag_a;
    logic [DATA_WIDTH-1:0]     w_mag_b;
    logic                      w_div_zero;
    logic                      w_ovf;
    logic [DATA_WIDTH-1:0]     w_special_res;
    logic [DATA_WIDTH+1:0]     w_sub;
    logic                      w_ge;
    logic [DATA_WIDTH-1:0]     w_q_fix;
    logic [DATA_WIDTH-1:0]     w_r_fix;

    assign w_accept_acq = (r_state == S_FREE) && bus.divAcquire && !bus.flush;
    assign w_start      = (r_state == S_RESERVED) && bus.divReq && !bus.stall && !bus.flush;
    assign w_last       = r_special || (r_iter == CW'(DATA_WIDTH));

    // Operand conditioning at the RESERVED->PROCESSING transition.
    assign w_signed   = !bus.divCode[0];
    assign w_neg_a    = w_signed && bus.dataInA[DATA_WIDTH-1];
    assign w_neg_b    = w_signed && bus.dataInB[DATA_WIDTH-1];
    assign w_mag_a    = w_neg_a ? (DATA_WIDTH'(0) - bus.dataInA) : bus.dataInA;
    assign w_mag_b    = w_neg_b ? (DATA_WIDTH'(0) - bus.dataInB) : bus.dataInB;
    assign w_div_zero = (bus.dataInB == '0);
    assign w_ovf      = w_signed && (bus.dataInA == MIN_NEG) && (bus.dataInB == '1);

    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = bus.divCode[1] ? bus.dataInA : '1;
        end else begin
            w_special_res = bus.divCode[1] ? '0 : bus.dataInA;
        end
    end

    // One restoring step on {partial remainder, next dividend bit}. The
    // (DATA_WIDTH+2)-bit difference cannot overflow because the shifted value
    // is always below twice the divisor, so its MSB is a clean borrow flag.
    assign w_sub = {r_rem, r_quo[DATA_WIDTH-1]} - (DATA_WIDTH+2)'(r_div);
    assign w_ge  = !w_sub[DATA_WIDTH+1];

    assign w_q_fix = r_qneg ? (DATA_WIDTH'(0) - r_quo) : r_quo;
    assign w_r_fix = r_rneg ? (DATA_WIDTH'(0) - r_rem[DATA_WIDTH-1:0]) : r_rem[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FREE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FREE:       if (bus.divAcquire) w_next = S_RESERVED;
            S_RESERVED:   if (bus.divReq && !bus.stall) w_next = S_PROCESSING;
            S_PROCESSING: if (w_last) w_next = S_FINISHED;
            S_FINISHED:   if (bus.divRelease) w_next = S_FREE;
            default:      w_next = S_FREE;
        endcase
        if (bus.flush) begin
            w_next = S_FREE;
        end
    end

    always_comb begin
        bus.divFree     = 1'b0;
        bus.divReserved = 1'b0;
        bus.divBusy     = 1'b0;
        bus.divFinished = 1'b0;
        case (r_state)
            S_FREE:       bus.divFree     = 1'b1;
            S_RESERVED:   bus.divReserved = 1'b1;
            S_PROCESSING: bus.divBusy     = 1'b1;
            S_FINISHED:   bus.divFinished = 1'b1;
            default:      bus.divFree     = 1'b1;
        endcase
    end

    assign bus.divDataOut            = r_result;
    assign bus.reservedActiveListPtr = r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_code    <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_special <= 1'b0;
            r_iter    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_result  <= '0;
        end else begin
            if (w_accept_acq) begin
                r_ptr <= bus.acquireActiveListPtr;
            end
            if (w_start) begin
                r_code    <= bus.divCode;
                r_qneg    <= w_neg_a ^ w_neg_b;
                r_rneg    <= w_neg_a;
                r_special <= w_div_zero || w_ovf;
                r_iter    <= '0;
                r_rem     <= '0;
                r_quo     <= w_mag_a;
                r_div     <= w_mag_b;
                if (w_div_zero || w_ovf) begin
                    r_result <= w_special_res;
                end
            end else if ((r_state == S_PROCESSING) && !bus.flush && !r_special) begin
                if (r_iter != CW'(DATA_WIDTH)) begin
                    r_rem  <= w_ge ? w_sub[DATA_WIDTH:0] : {r_rem[DATA_WIDTH-1:0], r_quo[DATA_WIDTH-1]};
                    r_quo  <= {r_quo[DATA_WIDTH-2:0], w_ge};
                    r_iter <= r_iter + CW'(1);
                end else begin
                    // Fixup cycle: sign correction and quotient/remainder select.
                    r_result <= r_code[1] ? w_r_fix : w_q_fix;
                end
            end
        end
    end

    // Protocol misuse is tolerated (the input is ignored) but reported.
    a_acq_not_free: assert property (@(posedge clk) disable iff (rst)
        !(bus.divAcquire && (r_state != S_FREE)))
        else $warning("divAcquire ignored: slot not free");
    a_req_not_reserved: assert property (@(posedge clk) disable iff (rst)
        !(bus.divReq && (r_state != S_RESERVED)))
        else $warning("divReq ignored: slot not reserved");
    a_rel_not_finished: assert property (@(posedge clk) disable iff (rst)
        !(bus.divRelease && (r_state != S_FINISHED)))
        else $warning("divRelease ignored: slot not finished");
endmodule

// File: tb/tb_div_unit_slot.sv
module tb_div_unit_slot;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    div_unit_slot_if #(.DATA_WIDTH(32), .AL_INDEX_WIDTH(6)) bus ();

    div_unit_slot #(.DATA_WIDTH(32), .AL_INDEX_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush = 1'b0; bus.stall = 1'b0; bus.divAcquire = 1'b0;
        bus.acquireActiveListPtr = '0; bus.divReq = 1'b0;
        bus.dataInA = '0; bus.dataInB = '0; bus.divCode = '0; bus.divRelease = 1'b0;
    endtask

    // Acquire, idle one cycle, request; then count busy cycles until finished.
    task automatic run_op(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int busy, output bit done);
        bus.divAcquire = 1'b1; bus.acquireActiveListPtr = 6'h01;
        tick();
        bus.divAcquire = 1'b0;
        tick();
        bus.divReq = 1'b1; bus.divCode = code; bus.dataInA = a; bus.dataInB = b;
        tick();
        bus.divReq = 1'b0;
        busy = 0; done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.divFinished) begin
                done = 1'b1;
                break;
            end
            if (bus.divBusy) busy++;
            tick();
        end
        data = bus.divDataOut;
    endtask

    task automatic release_slot();
        bus.divRelease = 1'b1;
        tick();
        bus.divRelease = 1'b0;
    endtask

    task automatic recover();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.divFree !== 1'b1) begin errors++; $display("FAIL reset_free got=%b exp=1", bus.divFree); end
        checks++; if ({bus.divReserved, bus.divBusy, bus.divFinished} !== 3'b000) begin errors++;
            $display("FAIL reset_status got=%b exp=000", {bus.divReserved, bus.divBusy, bus.divFinished}); end
        checks++; if (bus.divDataOut !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.divDataOut); end
        checks++; if (bus.reservedActiveListPtr !== 6'h0) begin errors++;
            $display("FAIL reset_ptr got=%h exp=0", bus.reservedActiveListPtr); end
    endtask

    typedef struct {
        logic [1:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          busy;
    } vec_t;

    task automatic run_table(input string name, input vec_t v[]);
        logic [31:0] data;
        int          busy;
        bit          done;
        foreach (v[i]) begin
            run_op(v[i].code, v[i].a, v[i].b, data, busy, done);
            checks++;
            if (!done) begin
                errors++; $display("FAIL %s[%0d]_timeout got=not_finished exp=finished", name, i);
                recover();
                continue;
            end
            checks++; if (data !== v[i].exp) begin errors++;
                $display("FAIL %s[%0d]_data got=%h exp=%h", name, i, data, v[i].exp); end
            checks++; if (busy != v[i].busy) begin errors++;
                $display("FAIL %s[%0d]_busy_cycles got=%0d exp=%0d", name, i, busy, v[i].busy); end
            release_slot();
            checks++; if (bus.divFree !== 1'b1) begin errors++;
                $display("FAIL %s[%0d]_free_after_release got=%b exp=1", name, i, bus.divFree); end
        end
    endtask

    task automatic test_unsigned();
        vec_t v[] = '{
            '{2'd1, 32'd100,        32'd7,  32'd14,         33},
            '{2'd3, 32'd100,        32'd7,  32'd2,          33},
            '{2'd1, 32'hFFFF_FFFF,  32'h10, 32'h0FFF_FFFF,  33},
            '{2'd3, 32'hFFFF_FFFF,  32'h10, 32'h0000_000F,  33}
        };
        run_table("unsigned", v);
    endtask

    task automatic test_signed();
        vec_t v[] = '{
            '{2'd0, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33},
            '{2'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33},
            '{2'd0, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 33},
            '{2'd2, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 33}
        };
        run_table("signed", v);
    endtask

    task automatic test_special();
        vec_t v[] = '{
            '{2'd1, 32'd5,         32'd0,         32'hFFFF_FFFF, 1},
            '{2'd2, 32'd5,         32'd0,         32'd5,         1},
            '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
            '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1}
        };
        run_table("special", v);
    endtask

    task automatic test_handshake();
        bit done;
        bus.divReq = 1'b1; bus.divCode = 2'd1; bus.dataInA = 32'd20; bus.dataInB = 32'd6;
        tick();
        bus.divReq = 1'b0;
        checks++; if (bus.divFree !== 1'b1 || bus.divBusy !== 1'b0) begin errors++;
            $display("FAIL req_while_free got=free%b/busy%b exp=free1/busy0", bus.divFree, bus.divBusy); end

        bus.divAcquire = 1'b1; bus.acquireActiveListPtr = 6'h2A;
        tick();
        bus.divAcquire = 1'b0;
        checks++; if (bus.divReserved !== 1'b1) begin errors++; $display("FAIL acquire_reserved got=%b exp=1", bus.divReserved); end
        checks++; if (bus.reservedActiveListPtr !== 6'h2A) begin errors++;
            $display("FAIL acquire_ptr got=%h exp=2a", bus.reservedActiveListPtr); end

        bus.stall = 1'b1; bus.divReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.divReserved !== 1'b1) begin errors++;
                $display("FAIL stall_hold[%0d] got=reserved%b exp=reserved1", i, bus.divReserved); end
        end
        bus.stall = 1'b0;
        tick();
        bus.divReq = 1'b0;
        checks++; if (bus.divBusy !== 1'b1) begin errors++; $display("FAIL start_after_stall got=%b exp=1", bus.divBusy); end

        bus.divRelease = 1'b1;
        tick();
        bus.divRelease = 1'b0;
        checks++; if (bus.divBusy !== 1'b1) begin errors++; $display("FAIL early_release got=busy%b exp=busy1", bus.divBusy); end

        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.divFinished) begin done = 1'b1; break; end
            tick();
        end
        checks++; if (!done) begin errors++; $display("FAIL handshake_timeout got=not_finished exp=finished"); end
        checks++; if (bus.divDataOut !== 32'd3) begin errors++; $display("FAIL handshake_data got=%h exp=3", bus.divDataOut); end
        tick();
        checks++; if (bus.divFinished !== 1'b1 || bus.divDataOut !== 32'd3) begin errors++;
            $display("FAIL finished_hold got=fin%b/%h exp=fin1/3", bus.divFinished, bus.divDataOut); end

        bus.divRelease = 1'b1; bus.divAcquire = 1'b1; bus.acquireActiveListPtr = 6'h15;
        tick();
        bus.divRelease = 1'b0; bus.divAcquire = 1'b0;
        checks++; if (bus.divFree !== 1'b1 || bus.divReserved !== 1'b0) begin errors++;
            $display("FAIL release_with_acquire got=free%b/res%b exp=free1/res0", bus.divFree, bus.divReserved); end
        checks++; if (bus.reservedActiveListPtr !== 6'h2A) begin errors++;
            $display("FAIL lost_acquire_ptr got=%h exp=2a", bus.reservedActiveListPtr); end

        bus.divAcquire = 1'b1; bus.acquireActiveListPtr = 6'h15;
        tick();
        bus.divAcquire = 1'b0;
        checks++; if (bus.divReserved !== 1'b1 || bus.reservedActiveListPtr !== 6'h15) begin errors++;
            $display("FAIL reacquire got=res%b/%h exp=res1/15", bus.divReserved, bus.reservedActiveListPtr); end
        recover();
        checks++; if (bus.divFree !== 1'b1) begin errors++; $display("FAIL flush_reserved got=%b exp=1", bus.divFree); end
    endtask

    task automatic test_flush();
        logic [31:0] data;
        int          busy;
        bit          done;
        bus.divAcquire = 1'b1; bus.acquireActiveListPtr = 6'h07;
        tick();
        bus.divAcquire = 1'b0;
        bus.divReq = 1'b1; bus.divCode = 2'd1; bus.dataInA = 32'd1000; bus.dataInB = 32'd3;
        tick();
        bus.divReq = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (bus.divBusy !== 1'b1) begin errors++; $display("FAIL busy_before_flush got=%b exp=1", bus.divBusy); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.divFree !== 1'b1 || bus.divBusy !== 1'b0) begin errors++;
            $display("FAIL flush_mid_op got=free%b/busy%b exp=free1/busy0", bus.divFree, bus.divBusy); end

        run_op(2'd1, 32'd9, 32'd3, data, busy, done);
        checks++; if (!done || data !== 32'd3) begin errors++;
            $display("FAIL after_flush_div got=done%b/%h exp=done1/3", done, data); end
        if (done) release_slot(); else recover();

        bus.flush = 1'b1; bus.divAcquire = 1'b1;
        tick();
        bus.flush = 1'b0; bus.divAcquire = 1'b0;
        checks++; if (bus.divFree !== 1'b1 || bus.divReserved !== 1'b0) begin errors++;
            $display("FAIL flush_beats_acquire got=free%b/res%b exp=free1/res0", bus.divFree, bus.divReserved); end

        bus.divAcquire = 1'b1;
        tick();
        bus.divAcquire = 1'b0;
        bus.flush = 1'b1; bus.divReq = 1'b1;
        tick();
        bus.flush = 1'b0; bus.divReq = 1'b0;
        tick();
        checks++; if (bus.divFree !== 1'b1 || bus.divBusy !== 1'b0) begin errors++;
            $display("FAIL flush_discards_req got=free%b/busy%b exp=free1/busy0", bus.divFree, bus.divBusy); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_handshake();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
